// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Owns the single port of the shared instruction/data memory. Each cycle it
// arbitrates between the IF-stage fetch and the MEM-stage load/store, drives
// the memory inputs and captures the returned word into registered
// instruction and load-result holding registers (latency 1).
//
// Fairness: data accesses win by default. After MAX_DATA_RUN consecutive data
// grants, a pending fetch takes the port for one cycle.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   if_req, if_addr                 fetch request and byte address
//   dm_read_req, dm_write_req       load / store request (both = store)
//   dm_addr, dm_wdata, dm_funct3    load/store address, store data, width
//   mem_MemRead, mem_MemWrite       memory control
//   mem_function3, mem_addr         memory access width and word index
//   mem_data_in, mem_data_out       memory write data / combinational read data
//   inst_out, inst_valid            registered fetch result
//   load_data, load_valid           registered load result
//   stall_if, stall_pipe            request pending but not granted this cycle
//   misaligned_fault                one-cycle pulse on a suppressed misaligned access
//
// Build option: define MEM_ARB_MISALIGN_CHECK_EN to suppress misaligned
// accesses and report them on misaligned_fault. Without it the low address
// bits are ignored and misaligned_fault is tied 0.

module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 6,
    parameter int unsigned MAX_DATA_RUN = 1,
    parameter logic [31:0] NOP_INST     = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    input  logic              dm_read_req,
    input  logic              dm_write_req,
    input  logic [31:0]       dm_addr,
    input  logic [31:0]       dm_wdata,
    input  logic [2:0]        dm_funct3,
    output logic              mem_MemRead,
    output logic              mem_MemWrite,
    output logic [2:0]        mem_function3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data_in,
    input  logic [31:0]       mem_data_out,
    output logic [31:0]       inst_out,
    output logic              inst_valid,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              stall_if,
    output logic              stall_pipe,
    output logic              misaligned_fault
);

    localparam logic [3:0] MaxRun = 4'(MAX_DATA_RUN);

    logic        dreq;
    logic        data_grant;
    logic        fetch_grant;
    logic        data_mis;
    logic        fetch_mis;
    logic        fetch_ok;
    logic        load_ok;
    logic [3:0]  data_run_q, data_run_d;
    logic [31:0] inst_q;
    logic        inst_valid_q;
    logic [31:0] load_q;
    logic        load_valid_q;

    assign dreq        = dm_read_req | dm_write_req;
    // A pending fetch only blocks data once the data run has hit its limit.
    assign data_grant  = dreq & ~(if_req & (data_run_q == MaxRun));
    assign fetch_grant = if_req & ~data_grant;

    assign stall_if   = rst_n & if_req & ~fetch_grant;
    assign stall_pipe = rst_n & dreq & ~data_grant;

`ifdef MEM_ARB_MISALIGN_CHECK_EN
    logic fault_q;
    logic unused_addr_bits;

    always_comb begin
        data_mis = 1'b0;
        unique case (dm_funct3)
            3'b001, 3'b101: data_mis = dm_addr[0];
            3'b010:         data_mis = (dm_addr[1:0] != 2'b00);
            default:        data_mis = 1'b0;
        endcase
    end
    assign fetch_mis = (if_addr[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= (data_grant & data_mis) | (fetch_grant & fetch_mis);
        end
    end
    assign misaligned_fault = fault_q;

    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], dm_addr[31:ADDR_W+2]};
`else
    logic unused_addr_bits;

    assign data_mis         = 1'b0;
    assign fetch_mis        = 1'b0;
    assign misaligned_fault = 1'b0;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                dm_addr[31:ADDR_W+2], dm_addr[1:0]};
`endif

    // A read/write collision is a store, so only a pure read returns load data.
    assign fetch_ok = fetch_grant & ~fetch_mis;
    assign load_ok  = data_grant & dm_read_req & ~dm_write_req & ~data_mis;

    // Memory drive; with no grant, addr/function3 follow the data side.
    always_comb begin
        mem_MemRead   = 1'b0;
        mem_MemWrite  = 1'b0;
        mem_function3 = dm_funct3;
        mem_addr      = dm_addr[ADDR_W+1:2];
        if (fetch_grant) begin
            mem_MemRead   = ~fetch_mis;
            mem_function3 = 3'b010;
            mem_addr      = if_addr[ADDR_W+1:2];
        end else if (data_grant) begin
            if (dm_write_req) begin
                mem_MemWrite = ~data_mis;
            end else begin
                mem_MemRead = ~data_mis;
            end
        end
        // No memory activity at all while reset is held.
        if (!rst_n) begin
            mem_MemRead  = 1'b0;
            mem_MemWrite = 1'b0;
        end
    end

    assign mem_data_in = dm_wdata;

    always_comb begin
        data_run_d = 4'd0;
        if (data_grant) begin
            data_run_d = (data_run_q == MaxRun) ? data_run_q : data_run_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inst_q       <= NOP_INST;
            inst_valid_q <= 1'b0;
            load_q       <= 32'd0;
            load_valid_q <= 1'b0;
            data_run_q   <= 4'd0;
        end else begin
            inst_valid_q <= fetch_ok;
            load_valid_q <= load_ok;
            data_run_q   <= data_run_d;
            if (fetch_ok) begin
                inst_q <= mem_data_out;
            end
            if (load_ok) begin
                load_q <= mem_data_out;
            end
        end
    end

    assign inst_out   = inst_q;
    assign inst_valid = inst_valid_q;
    assign load_data  = load_q;
    assign load_valid = load_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural word memory, directed stimulus,
// scoreboard queues for fetched instructions and load results.

module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req;
    logic [31:0]       if_addr;
    logic              dm_read_req;
    logic              dm_write_req;
    logic [31:0]       dm_addr;
    logic [31:0]       dm_wdata;
    logic [2:0]        dm_funct3;
    logic              mem_MemRead;
    logic              mem_MemWrite;
    logic [2:0]        mem_function3;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data_in;
    logic [31:0]       mem_data_out;
    logic [31:0]       inst_out;
    logic              inst_valid;
    logic [31:0]       load_data;
    logic              load_valid;
    logic              stall_if;
    logic              stall_pipe;
    logic              misaligned_fault;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_inst[$];
    logic [31:0] exp_load[$];

    mem_port_arbiter #(
        .ADDR_W       (ADDR_W),
        .MAX_DATA_RUN (1),
        .NOP_INST     (32'h00000013)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_req           (if_req),
        .if_addr          (if_addr),
        .dm_read_req      (dm_read_req),
        .dm_write_req     (dm_write_req),
        .dm_addr          (dm_addr),
        .dm_wdata         (dm_wdata),
        .dm_funct3        (dm_funct3),
        .mem_MemRead      (mem_MemRead),
        .mem_MemWrite     (mem_MemWrite),
        .mem_function3    (mem_function3),
        .mem_addr         (mem_addr),
        .mem_data_in      (mem_data_in),
        .mem_data_out     (mem_data_out),
        .inst_out         (inst_out),
        .inst_valid       (inst_valid),
        .load_data        (load_data),
        .load_valid       (load_valid),
        .stall_if         (stall_if),
        .stall_pipe       (stall_pipe),
        .misaligned_fault (misaligned_fault)
    );

    always #5 clk = ~clk;

    // Behavioural DataMem: combinational read, write at the clock edge.
    logic [31:0] mem [0:63];
    logic        mem_init = 1'b0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
            mem[0]   <= 32'd100;
            mem[2]   <= 32'hFFFFFF9C;
            mem[3]   <= 32'd200;
            mem_init <= 1'b1;
        end else if (mem_MemWrite) begin
            mem[mem_addr] <= mem_data_in;
        end
    end

    assign mem_data_out = mem[mem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per valid output.
    always @(negedge clk) begin
        if (inst_valid) begin
            if (exp_inst.size() == 0) begin
                total++;
                bad++;
                $display("FAIL inst_unexpected: got %h expected no fetch result", inst_out);
            end else begin
                check("inst_out", inst_out, exp_inst.pop_front());
            end
        end
        if (load_valid) begin
            if (exp_load.size() == 0) begin
                total++;
                bad++;
                $display("FAIL load_unexpected: got %h expected no load result", load_data);
            end else begin
                check("load_data", load_data, exp_load.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic ifr, input logic [31:0] ia, input logic rd, input logic wr,
                       input logic [31:0] da, input logic [31:0] wd, input logic [2:0] f3);
        if_req       = ifr;
        if_addr      = ia;
        dm_read_req  = rd;
        dm_write_req = wr;
        dm_addr      = da;
        dm_wdata     = wd;
        dm_funct3    = f3;
    endtask

    initial begin
        // Reset held with requests pending: no memory activity, no stalls.
        rst_n = 1'b0;
        drv(1'b1, 32'h0, 1'b0, 1'b1, 32'h10, 32'd5, 3'b010);
        #2;
        check("rst_memwrite", {31'd0, mem_MemWrite}, 32'd0);
        check("rst_memread", {31'd0, mem_MemRead}, 32'd0);
        check("rst_stall_if", {31'd0, stall_if}, 32'd0);
        check("rst_stall_pipe", {31'd0, stall_pipe}, 32'd0);
        tick();
        tick();
        check("rst_inst_out", inst_out, 32'h00000013);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_load_valid", {31'd0, load_valid}, 32'd0);
        check("rst_fault", {31'd0, misaligned_fault}, 32'd0);

        // Plain fetch of mem[0].
        rst_n = 1'b1;
        drv(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'd0, 3'b010);
        #1;
        check("f1_stall_if", {31'd0, stall_if}, 32'd0);
        check("f1_memread", {31'd0, mem_MemRead}, 32'd1);
        check("f1_addr", {26'd0, mem_addr}, 32'd0);
        exp_inst.push_back(32'd100);
        tick();

        // Plain load of mem[2].
        drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 32'd0, 3'b010);
        #1;
        check("l1_stall_pipe", {31'd0, stall_pipe}, 32'd0);
        check("l1_addr", {26'd0, mem_addr}, 32'd2);
        exp_load.push_back(32'hFFFFFF9C);
        tick();

        // Idle: clears the data run, no access.
        drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'd0, 3'b010);
        #1;
        check("idle_memread", {31'd0, mem_MemRead}, 32'd0);
        check("idle_memwrite", {31'd0, mem_MemWrite}, 32'd0);
        tick();

        // Contention: data, then fetch (run limit 1), then data again.
        drv(1'b1, 32'h8, 1'b1, 1'b0, 32'hC, 32'd0, 3'b010);
        #1;
        check("c1_stall_if", {31'd0, stall_if}, 32'd1);
        check("c1_stall_pipe", {31'd0, stall_pipe}, 32'd0);
        check("c1_addr", {26'd0, mem_addr}, 32'd3);
        exp_load.push_back(32'd200);
        tick();
        #1;
        check("c2_stall_if", {31'd0, stall_if}, 32'd0);
        check("c2_stall_pipe", {31'd0, stall_pipe}, 32'd1);
        check("c2_addr", {26'd0, mem_addr}, 32'd2);
        check("c2_funct3", {29'd0, mem_function3}, 32'd2);
        exp_inst.push_back(32'hFFFFFF9C);
        tick();
        #1;
        check("c3_stall_if", {31'd0, stall_if}, 32'd1);
        check("c3_stall_pipe", {31'd0, stall_pipe}, 32'd0);
        exp_load.push_back(32'd200);
        tick();

        drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'd0, 3'b010);
        tick();

        // Store 6 to word 4, read it back, then fetch via aliased address.
        drv(1'b0, 32'h0, 1'b0, 1'b1, 32'h10, 32'd6, 3'b010);
        #1;
        check("st_memwrite", {31'd0, mem_MemWrite}, 32'd1);
        check("st_memread", {31'd0, mem_MemRead}, 32'd0);
        check("st_addr", {26'd0, mem_addr}, 32'd4);
        check("st_wdata", mem_data_in, 32'd6);
        tick();
        drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'd0, 3'b010);
        exp_load.push_back(32'd6);
        tick();
        drv(1'b1, 32'h110, 1'b0, 1'b0, 32'h0, 32'd0, 3'b010);
        #1;
        check("wrap_addr", {26'd0, mem_addr}, 32'd4);
        exp_inst.push_back(32'd6);
        tick();

        // Read and write together act as a store only.
        drv(1'b0, 32'h0, 1'b1, 1'b1, 32'h14, 32'd9, 3'b010);
        #1;
        check("rw_memwrite", {31'd0, mem_MemWrite}, 32'd1);
        check("rw_memread", {31'd0, mem_MemRead}, 32'd0);
        tick();
        drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h14, 32'd0, 3'b010);
        exp_load.push_back(32'd9);
        tick();

        // Reset during a store: memory untouched, outputs back to reset values.
        rst_n = 1'b0;
        drv(1'b0, 32'h0, 1'b0, 1'b1, 32'h10, 32'd77, 3'b010);
        #1;
        check("rst2_memwrite", {31'd0, mem_MemWrite}, 32'd0);
        check("rst2_stall_pipe", {31'd0, stall_pipe}, 32'd0);
        tick();
        check("rst2_inst_out", inst_out, 32'h00000013);
        check("rst2_load_data", load_data, 32'd0);
        check("rst2_inst_valid", {31'd0, inst_valid}, 32'd0);
        rst_n = 1'b1;
        drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'd0, 3'b010);
        exp_load.push_back(32'd6);
        tick();

        // Word load at byte address 6.
        drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h6, 32'd0, 3'b010);
        #1;
        check("mis_stall_pipe", {31'd0, stall_pipe}, 32'd0);
`ifdef MEM_ARB_MISALIGN_CHECK_EN
        check("mis_memread", {31'd0, mem_MemRead}, 32'd0);
        tick();
        drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'd0, 3'b010);
        #1;
        check("mis_fault_pulse", {31'd0, misaligned_fault}, 32'd1);
        tick();
        check("mis_fault_drop", {31'd0, misaligned_fault}, 32'd0);
`else
        check("mis_memread", {31'd0, mem_MemRead}, 32'd1);
        exp_load.push_back(32'd0);
        tick();
        drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'd0, 3'b010);
        #1;
        check("mis_fault_tied", {31'd0, misaligned_fault}, 32'd0);
        tick();
`endif
        tick();
        tick();
        check("inst_queue_left", exp_inst.size(), 32'd0);
        check("load_queue_left", exp_load.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
